// File: rtl/ped_call_unit.sv
// ============================================================================
// Module  : ped_call_unit
// Brief   : Pedestrian call latch with minimum wait, walk handshake, post-walk
//           hold-off, saturating press counter and wait indicator LED.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ped_call_unit #(
  parameter int C_MIN_WAIT = 3,
  parameter int C_HOLDOFF  = 2,
  parameter int C_CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blink,
  input  logic               inBtn,
  input  logic               inWalk,
  output logic               outReq,
  output logic               outWaitLed,
  output logic [C_CNT_W-1:0] outPresses
);

  localparam int C_MAXP = (C_MIN_WAIT > C_HOLDOFF) ? C_MIN_WAIT : C_HOLDOFF;
  localparam int C_TW   = (C_MAXP > 1) ? $clog2(C_MAXP) : 1;

  localparam logic [C_TW-1:0] C_WAIT_LAST = C_TW'((C_MIN_WAIT > 0) ? C_MIN_WAIT - 1 : 0);
  localparam logic [C_TW-1:0] C_HOLD_LAST = C_TW'((C_HOLDOFF > 0) ? C_HOLDOFF - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CALL    = 3'd2,
    S_SERVED  = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_TW-1:0]      cnt_q, cnt_d;
  logic [C_CNT_W-1:0]   presses_q, presses_d;
  logic                 btn_q, blink_q;
  logic                 req_q, led_q;
  logic                 press, tick;

  assign press = inBtn & ~btn_q;
  assign tick  = blink & ~blink_q;

  // Single counter serves as waitCnt in ARMED and holdCnt in HOLDOFF.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presses_d = presses_q;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d   = (C_MIN_WAIT == 0) ? S_CALL : S_ARMED;
          cnt_d     = '0;
          presses_d = C_CNT_W'(1);
        end
      end
      S_ARMED: begin
        if (inWalk) begin
          state_d   = S_SERVED;
          presses_d = '0;
        end else begin
          if (press && presses_q != '1) presses_d = presses_q + C_CNT_W'(1);
          if (tick) begin
            if (cnt_q == C_WAIT_LAST) state_d = S_CALL;
            else                      cnt_d   = cnt_q + C_TW'(1);
          end
        end
      end
      S_CALL: begin
        if (inWalk) begin
          state_d   = S_SERVED;
          presses_d = '0;
        end else if (press && presses_q != '1) begin
          presses_d = presses_q + C_CNT_W'(1);
        end
      end
      S_SERVED: begin
        presses_d = '0;
        if (!inWalk) begin
          state_d = (C_HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
          cnt_d   = '0;
        end
      end
      S_HOLDOFF: begin
        if (tick) begin
          if (cnt_q == C_HOLD_LAST) state_d = S_IDLE;
          else                      cnt_d   = cnt_q + C_TW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        presses_d = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change with the state register.
  always_ff @(posedge clk) begin
    btn_q   <= inBtn;
    blink_q <= blink;
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      presses_q <= '0;
      req_q     <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presses_q <= presses_d;
      req_q     <= (state_d == S_CALL);
      led_q     <= (state_d == S_SERVED) |
                   (((state_d == S_ARMED) | (state_d == S_CALL)) & blink);
    end
  end

  assign outReq     = req_q;
  assign outWaitLed = led_q;
  assign outPresses = presses_q;

endmodule

`default_nettype wire
